// File: rtl/axi_address_decoder_aw_ot.sv
// AXI write-address decoder for one crossbar slave port, with outstanding tracking and internal DECERR handling.
// Optional feature: define AXI_DEC_ORDER_LOCK_EN to hold new writes to a different port until outstanding writes drain.
module axi_address_decoder_aw_ot #(
  parameter int ADDR_WIDTH      = 32,
  parameter int N_INIT_PORT     = 8,
  parameter int N_REGION        = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 awvalid_i,
  input  logic [ADDR_WIDTH-1:0]                                awaddr_i,
  input  logic [LEN_WIDTH-1:0]                                 awlen_i,
  output logic                                                 awready_o,
  output logic [N_INIT_PORT-1:0]                               awvalid_o,
  input  logic [N_INIT_PORT-1:0]                               awready_i,
  input  logic                                                 grant_FIFO_DEST_i,
  output logic [N_INIT_PORT-1:0]                               DEST_o,
  output logic                                                 push_DEST_o,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
  input  logic [N_INIT_PORT-1:0]                               connectivity_map_i,
  input  logic                                                 b_done_i,
  input  logic                                                 wvalid_i,
  input  logic                                                 wlast_i,
  output logic                                                 err_wready_o,
  output logic                                                 err_bvalid_o,
  input  logic                                                 err_bready_i
);

  localparam int OT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OT_W-1:0] OT_MAX = OT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {OPERATIVE, DRAIN, SINK_W, ERR_RESP} state_t;

  state_t                 state;
  logic [OT_W-1:0]        ot_cnt;
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic [LEN_WIDTH-1:0]   err_len;
  logic [N_INIT_PORT-1:0] hit_raw;
  logic [N_INIT_PORT-1:0] hit;
  logic [N_INIT_PORT-1:0] dest;
  logic                   dest_found;
  logic                   is_hit;
  logic                   stall;
  logic                   miss_accept;
  logic                   ot_dec;
`ifdef AXI_DEC_ORDER_LOCK_EN
  logic [N_INIT_PORT-1:0] last_dest;
`endif

  // Region match per port, then connectivity mask
  always_comb begin
    hit_raw = '0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      for (int r = 0; r < N_REGION; r++) begin
        if (enable_region_i[r][p] &&
            (awaddr_i >= START_ADDR_i[r][p]) &&
            (awaddr_i <= END_ADDR_i[r][p])) begin
          hit_raw[p] = 1'b1;
        end
      end
    end
  end

  assign hit = hit_raw & connectivity_map_i;

  // Lowest port index wins on overlapping hits
  always_comb begin
    dest       = '0;
    dest_found = 1'b0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      if (hit[p] && !dest_found) begin
        dest[p]    = 1'b1;
        dest_found = 1'b1;
      end
    end
  end

  assign DEST_o = dest;
  assign is_hit = |hit;

`ifdef AXI_DEC_ORDER_LOCK_EN
  assign stall = (ot_cnt == OT_MAX) || !grant_FIFO_DEST_i ||
                 ((ot_cnt != '0) && (dest != last_dest));
`else
  assign stall = (ot_cnt == OT_MAX) || !grant_FIFO_DEST_i;
`endif

  // Routing is combinational so a hit handshakes in the same cycle
  always_comb begin
    awvalid_o   = '0;
    awready_o   = 1'b0;
    miss_accept = 1'b0;
    if (state == OPERATIVE) begin
      if (is_hit) begin
        if (!stall) begin
          awvalid_o = dest & {N_INIT_PORT{awvalid_i}};
          awready_o = |(awready_i & dest);
        end
      end else if (awvalid_i) begin
        awready_o   = 1'b1;
        miss_accept = 1'b1;
      end
    end
  end

  assign push_DEST_o = |(awvalid_o & awready_i);
  assign ot_dec      = b_done_i && (ot_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ot_cnt <= '0;
    end else if (push_DEST_o && !ot_dec) begin
      ot_cnt <= ot_cnt + OT_W'(1);
    end else if (!push_DEST_o && ot_dec) begin
      ot_cnt <= ot_cnt - OT_W'(1);
    end
  end

`ifdef AXI_DEC_ORDER_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dest <= '0;
    end else if (push_DEST_o) begin
      last_dest <= dest;
    end
  end
`endif

  // Burst length of the missed write; only read while sinking, so no reset needed
  always_ff @(posedge clk) begin
    if (miss_accept) begin
      err_len <= awlen_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= OPERATIVE;
      beat_cnt     <= '0;
      err_wready_o <= 1'b0;
      err_bvalid_o <= 1'b0;
    end else begin
      case (state)
        OPERATIVE: begin
          if (miss_accept) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ot_cnt == '0) begin
            state        <= SINK_W;
            err_wready_o <= 1'b1;
          end
        end
        SINK_W: begin
          if (wvalid_i) begin
            if (wlast_i || (beat_cnt == err_len)) begin
              state        <= ERR_RESP;
              beat_cnt     <= '0;
              err_wready_o <= 1'b0;
              err_bvalid_o <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        ERR_RESP: begin
          if (err_bready_i) begin
            state        <= OPERATIVE;
            err_bvalid_o <= 1'b0;
          end
        end
        default: begin
          state <= OPERATIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_address_decoder_aw_ot.sv
// Directed bench for axi_address_decoder_aw_ot: decode table plus outstanding, lock, miss and reset sequences.
module tb_axi_address_decoder_aw_ot;

  localparam int AW = 32;
  localparam int NP = 8;
  localparam int NR = 2;
  localparam int MO = 2;
  localparam int LW = 8;

  logic                          clk;
  logic                          rst_n;
  logic                          awvalid;
  logic [AW-1:0]                 awaddr;
  logic [LW-1:0]                 awlen;
  logic                          awready_o;
  logic [NP-1:0]                 awvalid_o;
  logic [NP-1:0]                 awready_i;
  logic                          grant;
  logic [NP-1:0]                 dest_o;
  logic                          push_o;
  logic [NR-1:0][NP-1:0][AW-1:0] start_addr;
  logic [NR-1:0][NP-1:0][AW-1:0] end_addr;
  logic [NR-1:0][NP-1:0]         en_region;
  logic [NP-1:0]                 conn_map;
  logic                          b_done;
  logic                          wvalid;
  logic                          wlast;
  logic                          err_wready_o;
  logic                          err_bvalid_o;
  logic                          err_bready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axi_address_decoder_aw_ot #(
    .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR),
    .MAX_OUTSTANDING(MO), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid_i(awvalid), .awaddr_i(awaddr), .awlen_i(awlen), .awready_o(awready_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .grant_FIFO_DEST_i(grant), .DEST_o(dest_o), .push_DEST_o(push_o),
    .START_ADDR_i(start_addr), .END_ADDR_i(end_addr),
    .enable_region_i(en_region), .connectivity_map_i(conn_map),
    .b_done_i(b_done),
    .wvalid_i(wvalid), .wlast_i(wlast), .err_wready_o(err_wready_o),
    .err_bvalid_o(err_bvalid_o), .err_bready_i(err_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [NP-1:0] dest;
    logic          rdy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1000, 8'h04, 1'b1};
    vecs[1]  = '{32'h0000_1FFF, 8'h04, 1'b1};
    vecs[2]  = '{32'h0000_0FFF, 8'h00, 1'b0};
    vecs[3]  = '{32'h0000_2000, 8'h02, 1'b1};
    vecs[4]  = '{32'h0000_2800, 8'h02, 1'b1};
    vecs[5]  = '{32'h0000_8000, 8'h01, 1'b1};
    vecs[6]  = '{32'h0000_3000, 8'h00, 1'b0};
    vecs[7]  = '{32'h0000_4000, 8'h00, 1'b0};
    vecs[8]  = '{32'h0000_5000, 8'h40, 1'b1};
    vecs[9]  = '{32'h0000_50FF, 8'h40, 1'b1};
    vecs[10] = '{32'h0000_5100, 8'h00, 1'b0};
    vecs[11] = '{32'hFFFF_FFFF, 8'h00, 1'b0};

    start_addr = '1;
    end_addr   = '0;
    en_region  = '0;
    start_addr[0][2] = 32'h1000; end_addr[0][2] = 32'h1FFF; en_region[0][2] = 1'b1;
    start_addr[1][1] = 32'h2000; end_addr[1][1] = 32'h2FFF; en_region[1][1] = 1'b1;
    start_addr[0][3] = 32'h2000; end_addr[0][3] = 32'h27FF; en_region[0][3] = 1'b1;
    start_addr[0][0] = 32'h8000; end_addr[0][0] = 32'h8FFF; en_region[0][0] = 1'b1;
    start_addr[1][5] = 32'h3000; end_addr[1][5] = 32'h3FFF; en_region[1][5] = 1'b1;
    start_addr[0][4] = 32'h4000; end_addr[0][4] = 32'h4FFF; en_region[0][4] = 1'b0;
    start_addr[1][6] = 32'h5000; end_addr[1][6] = 32'h50FF; en_region[1][6] = 1'b1;
    conn_map = 8'b1101_1111;

    rst_n = 1'b0; awvalid = 1'b0; awaddr = '0; awlen = '0; awready_i = '0;
    grant = 1'b1; b_done = 1'b0; wvalid = 1'b0; wlast = 1'b0; err_bready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_push", push_o, 0);
    chk("rst_err_wready", err_wready_o, 0);
    chk("rst_err_bvalid", err_bvalid_o, 0);
    chk("rst_ot_cnt", dut.ot_cnt, 0);
    step();
    rst_n = 1'b1;

    // Decode table, no handshakes
    awready_i = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      step();
      awaddr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("dec_dest[%0d]", i), dest_o, vecs[i].dest);
      chk($sformatf("dec_rdy[%0d]", i), awready_o, vecs[i].rdy);
    end

    // First routed write, same-cycle handshake
    step();
    awvalid = 1'b1; awaddr = 32'h1000; awready_i = 8'h04;
    @(negedge clk);
    chk("aw1_awvalid", awvalid_o, 8'h04);
    chk("aw1_awready", awready_o, 1);
    chk("aw1_push", push_o, 1);
    step();
    chk("aw1_ot", dut.ot_cnt, 1);
    @(negedge clk);
    chk("aw2_push", push_o, 1);
    step();
    chk("aw2_ot", dut.ot_cnt, 2);
    @(negedge clk);
    chk("full_awready", awready_o, 0);
    chk("full_awvalid", awvalid_o, 0);
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    @(negedge clk);
    chk("after_bdone_awready", awready_o, 1);
    chk("after_bdone_push", push_o, 1);
    step();
    awvalid = 1'b0;
    chk("refill_ot", dut.ot_cnt, 2);
    b_done = 1'b1;
    step();
    awvalid = 1'b1;
    @(negedge clk);
    chk("simul_push", push_o, 1);
    step();
    chk("simul_ot", dut.ot_cnt, 1);
    awvalid = 1'b0;
    step();
    b_done = 1'b0;
    chk("drain_ot", dut.ot_cnt, 0);

    // FIFO grant low stalls a hit
    grant = 1'b0; awvalid = 1'b1; awaddr = 32'h1000;
    @(negedge clk);
    chk("nogrant_awvalid", awvalid_o, 0);
    chk("nogrant_push", push_o, 0);
    step();
    grant = 1'b1;
    @(negedge clk);
    chk("grant_push", push_o, 1);
    step();
    awvalid = 1'b0;
    b_done = 1'b1;
    step();
    b_done = 1'b0;

    // Ordering lock: port 0 outstanding, then port 1
    awready_i = 8'hFF; awvalid = 1'b1; awaddr = 32'h8000;
    step();
    awaddr = 32'h2000;
    @(negedge clk);
`ifdef AXI_DEC_ORDER_LOCK_EN
    chk("lock_awvalid", awvalid_o, 0);
    chk("lock_awready", awready_o, 0);
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    @(negedge clk);
    chk("unlock_awvalid", awvalid_o, 8'h02);
    step();
    awvalid = 1'b0;
    b_done = 1'b1;
    step();
    b_done = 1'b0;
`else
    chk("nolock_awvalid", awvalid_o, 8'h02);
    chk("nolock_awready", awready_o, 1);
    step();
    awvalid = 1'b0;
    b_done = 1'b1;
    repeat (2) step();
    b_done = 1'b0;
`endif
    chk("lock_ot_zero", dut.ot_cnt, 0);

    // Miss with one write outstanding, awlen=3
    awvalid = 1'b1; awaddr = 32'h1000;
    step();
    awaddr = 32'h0FFF; awlen = 8'd3;
    @(negedge clk);
    chk("miss_awready", awready_o, 1);
    chk("miss_awvalid", awvalid_o, 0);
    chk("miss_push", push_o, 0);
    step();
    awaddr = 32'h1000;
    repeat (3) step();
    @(negedge clk);
    chk("drain_awready", awready_o, 0);
    chk("drain_awvalid", awvalid_o, 0);
    chk("drain_wready", err_wready_o, 0);
    awvalid = 1'b0;
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    step();
    wvalid = 1'b1; wlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("sink_wready[%0d]", i), err_wready_o, 1);
      step();
    end
    wvalid = 1'b0;
    chk("sink_done_wready", err_wready_o, 0);
    chk("errresp_bvalid", err_bvalid_o, 1);
    repeat (2) step();
    chk("errresp_hold", err_bvalid_o, 1);
    err_bready = 1'b1;
    step();
    err_bready = 1'b0;
    chk("errresp_done", err_bvalid_o, 0);
    awvalid = 1'b1; awaddr = 32'h1000;
    @(negedge clk);
    chk("post_err_push", push_o, 1);
    step();
    awvalid = 1'b0;
    b_done = 1'b1;
    step();
    b_done = 1'b0;

    // Early wlast ends the sink before err_len
    awvalid = 1'b1; awaddr = 32'h0FFF; awlen = 8'd7;
    step();
    awvalid = 1'b0;
    step();
    wvalid = 1'b1; wlast = 1'b0;
    step();
    wlast = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
    chk("wlast_bvalid", err_bvalid_o, 1);
    chk("wlast_wready", err_wready_o, 0);
    err_bready = 1'b1;
    step();
    err_bready = 1'b0;

    // Reset in the middle of SINK_W
    awvalid = 1'b1; awaddr = 32'h0FFF; awlen = 8'd7;
    step();
    awvalid = 1'b0;
    step();
    @(negedge clk);
    chk("pre_rst_wready", err_wready_o, 1);
    wvalid = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wready", err_wready_o, 0);
    wvalid = 1'b0;
    step();
    rst_n = 1'b1;
    chk("post_rst_state", int'(dut.state), 0);
    chk("post_rst_ot", dut.ot_cnt, 0);

    // Beat counter restarts from zero after reset
    awvalid = 1'b1; awaddr = 32'h0FFF; awlen = 8'd1;
    @(negedge clk);
    chk("post_rst_miss", awready_o, 1);
    step();
    awvalid = 1'b0;
    step();
    wvalid = 1'b1; wlast = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_beat1", err_wready_o, 1);
    step();
    wvalid = 1'b0;
    chk("post_rst_bvalid", err_bvalid_o, 1);
    err_bready = 1'b1;
    step();
    err_bready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
